// File: rtl/mem_access_arbiter.sv
// Purpose: arbitrates one single-port memory between a systolic-array (SA) burst master and a read-only FPGA viewer (FP).
// Latency: grant 1 cycle after a request seen in IDLE; read data and rvalid 1 cycle after the read beat.
// Backpressure: requesters hold *_req until granted; SA bursts end on sa_last or after MAX_BURST beats, then re-arbitrate.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   sa_req/we/addr/wdata/last      SA beat request (one beat per granted cycle with sa_req=1)
//   sa_gnt, sa_rvalid, sa_rdata    SA ownership and read return
//   fp_req/addr                    FPGA viewer single-beat read request
//   fp_gnt, fp_rvalid, fp_rdata    FPGA ownership and read return
//   switch_mem_access              toggles pref_owner once per cycle held high
//   mem_addr/we/wdata, mem_rdata   memory port (read data valid one cycle after the address)
//   pref_owner                     0 = SA preferred, 1 = FPGA preferred on simultaneous requests
module mem_access_arbiter #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sa_req,
    input  logic                     sa_we,
    input  logic [ADDR_W-1:0]        sa_addr,
    input  logic signed [WIDTH-1:0]  sa_wdata,
    input  logic                     sa_last,
    output logic                     sa_gnt,
    output logic                     sa_rvalid,
    output logic signed [WIDTH-1:0]  sa_rdata,
    input  logic                     fp_req,
    input  logic [ADDR_W-1:0]        fp_addr,
    output logic                     fp_gnt,
    output logic                     fp_rvalid,
    output logic signed [WIDTH-1:0]  fp_rdata,
    input  logic                     switch_mem_access,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic signed [WIDTH-1:0]  mem_wdata,
    input  logic signed [WIDTH-1:0]  mem_rdata,
    output logic                     pref_owner
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SA_OWN = 2'd1,
        FP_OWN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    pref_owner_q, pref_owner_d;
    logic                    sa_gnt_q, sa_gnt_d;
    logic                    fp_gnt_q, fp_gnt_d;
    logic                    sa_rvalid_q, sa_rvalid_d;
    logic                    fp_rvalid_q, fp_rvalid_d;
    logic signed [WIDTH-1:0] sa_rdata_q, sa_rdata_d;
    logic signed [WIDTH-1:0] fp_rdata_q, fp_rdata_d;

    logic sa_beat;
    logic burst_end;

    // Next-state, counter and registered-output logic.
    always_comb begin
        sa_beat   = (state_q == SA_OWN) && sa_req;
        // beat_cnt_q holds the number of beats already taken, so the
        // MAX_BURST-th beat is the one seen while the count is MAX_BURST-1.
        burst_end = sa_beat && (sa_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                // Arbitration uses the current pref_owner; a switch pulse in
                // this same cycle only affects later arbitrations.
                if (sa_req && (!fp_req || !pref_owner_q)) begin
                    state_d = SA_OWN;
                end else if (fp_req) begin
                    state_d = FP_OWN;
                end
            end
            SA_OWN: begin
                if (burst_end) begin
                    state_d = IDLE;
                end
            end
            FP_OWN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counter is zero whenever SA_OWN is entered and after each burst.
        beat_cnt_d = '0;
        if (sa_beat && !burst_end) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else if ((state_q == SA_OWN) && !sa_req) begin
            beat_cnt_d = beat_cnt_q;
        end

        sa_gnt_d     = (state_d == SA_OWN);
        fp_gnt_d     = (state_d == FP_OWN);
        pref_owner_d = pref_owner_q ^ switch_mem_access;

        // A return is owed only for reads actually issued to memory.
        sa_rvalid_d  = sa_beat && !sa_we;
        fp_rvalid_d  = (state_q == FP_OWN);
    end

    // Memory port: driven straight from the granted master's inputs so a
    // beat reaches memory in the cycle it is presented. The FPGA side can
    // never reach mem_we.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (sa_beat) begin
            mem_addr  = sa_addr;
            mem_we    = sa_we;
            mem_wdata = sa_wdata;
        end else if (state_q == FP_OWN) begin
            mem_addr  = fp_addr;
        end
    end

    // Read data passes through from memory in the return cycle and is held
    // in a register afterwards so rdata stays stable while rvalid is low.
    always_comb begin
        sa_rdata   = sa_rvalid_q ? mem_rdata : sa_rdata_q;
        fp_rdata   = fp_rvalid_q ? mem_rdata : fp_rdata_q;
        sa_rdata_d = sa_rdata;
        fp_rdata_d = fp_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            pref_owner_q <= 1'b0;
            sa_gnt_q     <= 1'b0;
            fp_gnt_q     <= 1'b0;
            sa_rvalid_q  <= 1'b0;
            fp_rvalid_q  <= 1'b0;
            sa_rdata_q   <= '0;
            fp_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            pref_owner_q <= pref_owner_d;
            sa_gnt_q     <= sa_gnt_d;
            fp_gnt_q     <= fp_gnt_d;
            sa_rvalid_q  <= sa_rvalid_d;
            fp_rvalid_q  <= fp_rvalid_d;
            sa_rdata_q   <= sa_rdata_d;
            fp_rdata_q   <= fp_rdata_d;
        end
    end

    assign sa_gnt     = sa_gnt_q;
    assign fp_gnt     = fp_gnt_q;
    assign sa_rvalid  = sa_rvalid_q;
    assign fp_rvalid  = fp_rvalid_q;
    assign pref_owner = pref_owner_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Purpose: directed and randomized checking of mem_access_arbiter against a memory model and scoreboard.
// Latency: one check step per clock; DUT outputs sampled 1 time unit after inputs settle at the falling edge.
// Backpressure: requesters hold their request until granted, SA bursts resume after a cap-induced release.
module tb_mem_access_arbiter;
    localparam int WIDTH     = 16;
    localparam int ADDR_W    = 12;
    localparam int MAX_BURST = 16;

    logic              clk;
    logic              rst;
    logic              sa_req, sa_we, sa_last;
    logic [ADDR_W-1:0] sa_addr;
    logic [WIDTH-1:0]  sa_wdata;
    logic              sa_gnt, sa_rvalid;
    logic [WIDTH-1:0]  sa_rdata;
    logic              fp_req;
    logic [ADDR_W-1:0] fp_addr;
    logic              fp_gnt, fp_rvalid;
    logic [WIDTH-1:0]  fp_rdata;
    logic              switch_mem_access;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;
    logic              pref_owner;

    mem_access_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .sa_req(sa_req), .sa_we(sa_we), .sa_addr(sa_addr), .sa_wdata(sa_wdata), .sa_last(sa_last),
        .sa_gnt(sa_gnt), .sa_rvalid(sa_rvalid), .sa_rdata(sa_rdata),
        .fp_req(fp_req), .fp_addr(fp_addr), .fp_gnt(fp_gnt), .fp_rvalid(fp_rvalid), .fp_rdata(fp_rdata),
        .switch_mem_access(switch_mem_access),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pref_owner(pref_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem_model [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] shadow [0:31];

    int n_checks;
    int n_pass;
    int n_fail;

    // burst-cap bookkeeping
    int   beats, grants, budget;
    int   per_grant [2];
    logic prev_gnt;

    // random-phase model state
    int               sa_rem, beats_in_grant;
    logic             sa_burst_we, fp_pending, pref_exp, end_burst;
    logic             have_exp_gnt, exp_sa_gnt, exp_fp_gnt;
    logic             sa_rv_exp, fp_rv_exp, sa_rv_exp_n, fp_rv_exp_n;
    logic [WIDTH-1:0] sa_rv_val, fp_rv_val, sa_last_val, fp_last_val;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered-read memory: the address presented this cycle is applied
    // at the rising edge and its data is visible for the whole next cycle.
    task automatic advance();
        logic [ADDR_W-1:0] a;
        logic              w;
        logic [WIDTH-1:0]  d;
        a = mem_addr;
        w = mem_we;
        d = mem_wdata;
        @(posedge clk);
        #1;
        if (w) mem_model[a] = d;
        mem_rdata = mem_model[a];
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = '0;

        rst = 1'b0;
        sa_req = 1'b0; sa_we = 1'b0; sa_addr = '0; sa_wdata = '0; sa_last = 1'b0;
        fp_req = 1'b0; fp_addr = '0; switch_mem_access = 1'b0; mem_rdata = '0;
        #2;
        chk1("rst_sa_gnt", sa_gnt, 1'b0);
        chk1("rst_fp_gnt", fp_gnt, 1'b0);
        chk1("rst_pref", pref_owner, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chka("rst_mem_addr", mem_addr, '0);
        chkw("rst_mem_wdata", mem_wdata, '0);
        chk1("rst_sa_rvalid", sa_rvalid, 1'b0);
        chk1("rst_fp_rvalid", fp_rvalid, 1'b0);
        chkw("rst_sa_rdata", sa_rdata, '0);
        chkw("rst_fp_rdata", fp_rdata, '0);
        @(negedge clk);
        rst = 1'b1;

        // Single FP read
        mem_model[5] = 16'h1234;
        fp_req = 1'b1; fp_addr = 12'h005; #1;
        chk1("fp_idle_gnt", fp_gnt, 1'b0);
        advance();
        fp_req = 1'b0; #1;
        chk1("fp_gnt", fp_gnt, 1'b1);
        chk1("fp_sa_gnt", sa_gnt, 1'b0);
        chka("fp_mem_addr", mem_addr, 12'h005);
        chk1("fp_mem_we", mem_we, 1'b0);
        advance(); #1;
        chk1("fp_gnt_drop", fp_gnt, 1'b0);
        chk1("fp_rvalid", fp_rvalid, 1'b1);
        chkw("fp_rdata", fp_rdata, 16'h1234);
        advance(); #1;
        chk1("fp_rvalid_once", fp_rvalid, 1'b0);
        chkw("fp_rdata_hold", fp_rdata, 16'h1234);

        // SA write burst of 4 beats
        sa_req = 1'b1; sa_we = 1'b1; sa_addr = '0; sa_wdata = 16'd10; sa_last = 1'b0; #1;
        chk1("saw_idle_gnt", sa_gnt, 1'b0);
        chk1("saw_idle_we", mem_we, 1'b0);
        advance();
        for (int i = 0; i < 4; i++) begin
            sa_addr = 12'(i); sa_wdata = 16'(10 + i); sa_last = (i == 3); #1;
            chk1("saw_gnt", sa_gnt, 1'b1);
            chk1("saw_we", mem_we, 1'b1);
            chka("saw_addr", mem_addr, 12'(i));
            chkw("saw_data", mem_wdata, 16'(10 + i));
            chk1("saw_no_rvalid", sa_rvalid, 1'b0);
            advance();
        end
        sa_req = 1'b0; sa_we = 1'b0; sa_last = 1'b0; #1;
        chk1("saw_end_gnt", sa_gnt, 1'b0);
        chk1("saw_end_we", mem_we, 1'b0);
        chk1("saw_end_rvalid", sa_rvalid, 1'b0);
        advance();

        // Contention with pref_owner=0: SA read burst first, FP after it
        sa_req = 1'b1; sa_we = 1'b0; sa_addr = 12'd1; sa_last = 1'b0;
        fp_req = 1'b1; fp_addr = 12'd3; #1;
        advance(); #1;
        chk1("ct_sa_first", sa_gnt, 1'b1);
        chk1("ct_fp_wait", fp_gnt, 1'b0);
        advance();
        sa_addr = 12'd2; sa_last = 1'b1; #1;
        chk1("ct_sa_rvalid", sa_rvalid, 1'b1);
        chkw("ct_sa_rdata", sa_rdata, 16'd11);
        chk1("ct_fp_wait2", fp_gnt, 1'b0);
        advance();
        sa_req = 1'b0; sa_last = 1'b0; #1;
        chk1("ct_sa_done", sa_gnt, 1'b0);
        chk1("ct_fp_wait3", fp_gnt, 1'b0);
        chkw("ct_sa_rdata2", sa_rdata, 16'd12);
        advance();
        fp_req = 1'b0; #1;
        chk1("ct_fp_gnt", fp_gnt, 1'b1);
        chka("ct_fp_addr", mem_addr, 12'd3);
        advance(); #1;
        chkw("ct_fp_rdata", fp_rdata, 16'd13);
        advance();

        // Switch pulse, then simultaneous requests: FP first, then SA
        switch_mem_access = 1'b1; #1;
        chk1("sw_pre", pref_owner, 1'b0);
        advance();
        switch_mem_access = 1'b0; #1;
        chk1("sw_post", pref_owner, 1'b1);
        sa_req = 1'b1; sa_we = 1'b0; sa_addr = '0; sa_last = 1'b1;
        fp_req = 1'b1; fp_addr = 12'd1; #1;
        advance();
        fp_req = 1'b0; #1;
        chk1("sw_fp_first", fp_gnt, 1'b1);
        chk1("sw_sa_wait", sa_gnt, 1'b0);
        advance(); #1;
        chk1("sw_idle_between", sa_gnt, 1'b0);
        chkw("sw_fp_rdata", fp_rdata, 16'd11);
        advance(); #1;
        chk1("sw_sa_second", sa_gnt, 1'b1);
        advance();
        sa_req = 1'b0; sa_last = 1'b0; #1;
        chk1("sw_sa_rvalid", sa_rvalid, 1'b1);
        chkw("sw_sa_rdata", sa_rdata, 16'd10);
        advance();

        // Switch held two cycles toggles twice
        switch_mem_access = 1'b1; #1;
        advance(); #1;
        chk1("sw_hold1", pref_owner, 1'b0);
        advance();
        switch_mem_access = 1'b0; #1;
        chk1("sw_hold2", pref_owner, 1'b1);

        // Switch in the same cycle as IDLE arbitration uses the old preference
        switch_mem_access = 1'b1; fp_req = 1'b1; fp_addr = 12'd2;
        sa_req = 1'b1; sa_we = 1'b0; sa_addr = 12'd3; sa_last = 1'b1; #1;
        advance();
        switch_mem_access = 1'b0; fp_req = 1'b0; #1;
        chk1("sw_same_cycle_fp", fp_gnt, 1'b1);
        chk1("sw_same_cycle_pref", pref_owner, 1'b0);
        advance(); #1;
        chkw("sw_same_fp_rdata", fp_rdata, 16'd12);
        advance(); #1;
        chk1("sw_same_sa_gnt", sa_gnt, 1'b1);
        advance();
        sa_req = 1'b0; sa_last = 1'b0; #1;
        chkw("sw_same_sa_rdata", sa_rdata, 16'd13);
        advance();

        // Burst cap: 20 write beats with no early sa_last
        sa_req = 1'b1; sa_we = 1'b1; sa_last = 1'b0;
        beats = 0; grants = 0; budget = 0; prev_gnt = 1'b0;
        per_grant[0] = 0; per_grant[1] = 0;
        while (beats < 20 && budget < 60) begin
            sa_addr = 12'(100 + beats); sa_wdata = 16'(beats); sa_last = (beats == 19); #1;
            if (sa_gnt) begin
                if (!prev_gnt) grants++;
                if (grants >= 1 && grants <= 2) per_grant[grants-1]++;
                chka("cap_addr", mem_addr, 12'(100 + beats));
                chk1("cap_we", mem_we, 1'b1);
                beats++;
            end
            prev_gnt = sa_gnt;
            advance();
            budget++;
        end
        sa_req = 1'b0; sa_we = 1'b0; sa_last = 1'b0; #1;
        chkw("cap_total", 16'(beats), 16'd20);
        chkw("cap_grants", 16'(grants), 16'd2);
        chkw("cap_first_grant", 16'(per_grant[0]), 16'd16);
        chkw("cap_second_grant", 16'(per_grant[1]), 16'd4);
        chk1("cap_end_idle", sa_gnt, 1'b0);
        advance();

        // Reset in the middle of an SA read burst
        sa_req = 1'b1; sa_we = 1'b0; sa_addr = 12'd105; sa_last = 1'b0; #1;
        advance();
        switch_mem_access = 1'b1; #1;
        chk1("rb_beat1_gnt", sa_gnt, 1'b1);
        advance();
        switch_mem_access = 1'b0; sa_addr = 12'd106; #1;
        chk1("rb_no_preempt", sa_gnt, 1'b1);
        chk1("rb_pref_toggled", pref_owner, 1'b1);
        chk1("rb_rvalid_pre", sa_rvalid, 1'b1);
        chkw("rb_rdata_pre", sa_rdata, 16'd5);
        #2;
        rst = 1'b0; #1;
        chk1("rb_gnt0", sa_gnt, 1'b0);
        chk1("rb_we0", mem_we, 1'b0);
        chka("rb_addr0", mem_addr, '0);
        chkw("rb_wdata0", mem_wdata, '0);
        chk1("rb_rvalid0", sa_rvalid, 1'b0);
        chkw("rb_rdata0", sa_rdata, '0);
        chk1("rb_pref0", pref_owner, 1'b0);
        advance();
        rst = 1'b1; sa_req = 1'b0; #1;
        chk1("rb_no_rvalid", sa_rvalid, 1'b0);
        chk1("rb_idle", sa_gnt, 1'b0);
        advance(); #1;
        chk1("rb_no_rvalid2", sa_rvalid, 1'b0);
        advance();

        // Randomized traffic against a scoreboard
        for (int i = 0; i < 32; i++) begin
            mem_model[i] = 16'(i * 7 + 3);
            shadow[i]    = 16'(i * 7 + 3);
        end
        sa_rem = 0; beats_in_grant = 0; sa_burst_we = 1'b0; fp_pending = 1'b0;
        pref_exp = 1'b0; have_exp_gnt = 1'b0; exp_sa_gnt = 1'b0; exp_fp_gnt = 1'b0;
        sa_rv_exp = 1'b0; fp_rv_exp = 1'b0; sa_rv_val = '0; fp_rv_val = '0;
        sa_last_val = '0; fp_last_val = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (sa_rem == 0 && $urandom_range(0, 3) == 0) begin
                sa_rem      = int'($urandom_range(1, 20));
                sa_burst_we = 1'($urandom_range(0, 1));
            end
            sa_req   = (sa_rem > 0) && ($urandom_range(0, 4) != 0);
            sa_we    = sa_burst_we;
            sa_addr  = 12'($urandom_range(0, 31));
            sa_wdata = 16'($urandom);
            sa_last  = (sa_rem == 1);
            if (!fp_pending && $urandom_range(0, 5) == 0) fp_pending = 1'b1;
            fp_req  = fp_pending;
            fp_addr = 12'($urandom_range(0, 31));
            switch_mem_access = ($urandom_range(0, 9) == 0);
            #1;

            chk1("rnd_pref", pref_owner, pref_exp);
            chk1("rnd_excl", sa_gnt & fp_gnt, 1'b0);
            if (have_exp_gnt) begin
                chk1("rnd_sa_gnt", sa_gnt, exp_sa_gnt);
                chk1("rnd_fp_gnt", fp_gnt, exp_fp_gnt);
            end
            chk1("rnd_sa_rvalid", sa_rvalid, sa_rv_exp);
            if (sa_rv_exp) begin
                chkw("rnd_sa_rdata", sa_rdata, sa_rv_val);
                sa_last_val = sa_rv_val;
            end else begin
                chkw("rnd_sa_hold", sa_rdata, sa_last_val);
            end
            chk1("rnd_fp_rvalid", fp_rvalid, fp_rv_exp);
            if (fp_rv_exp) begin
                chkw("rnd_fp_rdata", fp_rdata, fp_rv_val);
                fp_last_val = fp_rv_val;
            end else begin
                chkw("rnd_fp_hold", fp_rdata, fp_last_val);
            end

            sa_rv_exp_n = 1'b0;
            fp_rv_exp_n = 1'b0;
            if (sa_gnt) begin
                if (sa_req) begin
                    chk1("rnd_we", mem_we, sa_we);
                    chka("rnd_addr", mem_addr, sa_addr);
                    if (sa_we) begin
                        chkw("rnd_wdata", mem_wdata, sa_wdata);
                        shadow[sa_addr[4:0]] = sa_wdata;
                    end else begin
                        sa_rv_exp_n = 1'b1;
                        sa_rv_val   = shadow[sa_addr[4:0]];
                    end
                    beats_in_grant++;
                    sa_rem--;
                    end_burst  = sa_last || (beats_in_grant == MAX_BURST);
                    exp_sa_gnt = !end_burst;
                    if (end_burst) beats_in_grant = 0;
                end else begin
                    chk1("rnd_bubble_we", mem_we, 1'b0);
                    exp_sa_gnt = 1'b1;
                end
                exp_fp_gnt = 1'b0;
            end else if (fp_gnt) begin
                chka("rnd_fp_addr", mem_addr, fp_addr);
                chk1("rnd_fp_we", mem_we, 1'b0);
                fp_rv_exp_n = 1'b1;
                fp_rv_val   = shadow[fp_addr[4:0]];
                fp_pending  = 1'b0;
                exp_sa_gnt  = 1'b0;
                exp_fp_gnt  = 1'b0;
            end else begin
                chk1("rnd_idle_we", mem_we, 1'b0);
                chka("rnd_idle_addr", mem_addr, '0);
                if (sa_req && fp_req) begin
                    exp_sa_gnt = !pref_exp;
                    exp_fp_gnt = pref_exp;
                end else begin
                    exp_sa_gnt = sa_req;
                    exp_fp_gnt = fp_req;
                end
                beats_in_grant = 0;
            end
            have_exp_gnt = 1'b1;
            pref_exp = pref_exp ^ switch_mem_access;
            advance();
            sa_rv_exp = sa_rv_exp_n;
            fp_rv_exp = fp_rv_exp_n;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
